// File: rtl/aux_rail_seq_if.sv
// aux_rail_seq_if -- control/status bundle for the auxiliary rail sequencer.
//   master : the platform side (drives tick, requests, PWRGD, Dediprog busy)
//   slave  : the sequencer (drives VR enables, SRST#, status, fault mask, state)
// Signals:
//   i1mSCE       1 ms single-cycle enable
//   iGoOutFltSt  fault-clear request
//   iPwrReq      power request, low asks for power-down
//   ivPwrgd      per-rail PWRGD
//   iDediBusy_n  low while the Dediprog programmer owns the flash
//   ovVrEn       per-rail VR enable
//   oSrst_n      BMC SRST#
//   oAllPwrgd    all rails good in ON
//   oPwrFlt      sticky fault flag
//   ovFltRail    latched faulting-rail mask
//   ovState      FSM state encoding
interface aux_rail_seq_if #(
    parameter int NUM_RAILS = 4
);
    logic                 i1mSCE;
    logic                 iGoOutFltSt;
    logic                 iPwrReq;
    logic [NUM_RAILS-1:0] ivPwrgd;
    logic                 iDediBusy_n;
    logic [NUM_RAILS-1:0] ovVrEn;
    logic                 oSrst_n;
    logic                 oAllPwrgd;
    logic                 oPwrFlt;
    logic [NUM_RAILS-1:0] ovFltRail;
    logic [2:0]           ovState;

    modport master (
        output i1mSCE, iGoOutFltSt, iPwrReq, ivPwrgd, iDediBusy_n,
        input  ovVrEn, oSrst_n, oAllPwrgd, oPwrFlt, ovFltRail, ovState
    );

    modport slave (
        input  i1mSCE, iGoOutFltSt, iPwrReq, ivPwrgd, iDediBusy_n,
        output ovVrEn, oSrst_n, oAllPwrgd, oPwrFlt, ovFltRail, ovState
    );
endinterface

// File: rtl/aux_rail_seq.sv
// aux_rail_seq -- powers NUM_RAILS VR rails up in order (rail 0 first), checks
// PWRGD timeouts and losses, powers them down in reverse order, and gates the
// BMC SRST# release on a settle delay and Dediprog ownership of the flash.
// Ports:
//   iClk  system clock
//   iRst  synchronous active-high reset
//   bus   aux_rail_seq_if.slave (tick, requests, PWRGD in; enables/status out)
// Every output is a register; the comb blocks compute their next values.
module aux_rail_seq #(
    parameter int NUM_RAILS     = 4,
    parameter int PG_TIMEOUT_MS = 10,
    parameter int STABLE_MS     = 1,
    parameter int RST_DLY_MS    = 2
) (
    input  logic           iClk,
    input  logic           iRst,
    aux_rail_seq_if.slave  bus
);
    localparam int IW = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        STABLE  = 3'd1,
        RAMP_UP = 3'd2,
        ON      = 3'd3,
        RAMP_DN = 3'd4,
        FAULT   = 3'd5
    } state_t;

    state_t               state, state_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic [7:0]           cnt, cnt_nxt;
    logic [NUM_RAILS-1:0] vr_en, vr_en_nxt;
    logic [NUM_RAILS-1:0] flt_rail, flt_rail_nxt;
    logic [NUM_RAILS-1:0] fault_mask;
    logic                 srst_n, srst_n_nxt;
    logic                 all_pg, all_pg_nxt;
    logic                 pwr_flt, pwr_flt_nxt;
    logic                 fault, pg_cur, tmo;

    assign pg_cur = bus.ivPwrgd[idx];
    assign tmo    = (cnt == 8'(PG_TIMEOUT_MS));

    // Per-rail fault sources: during ramp-up the current rail can time out and
    // the rails already passed can drop; in ON any enabled rail can drop.
    always_comb begin
        fault_mask = '0;
        for (int r = 0; r < NUM_RAILS; r++) begin
            if (state == RAMP_UP) begin
                if ((IW'(r) < idx) && vr_en[r] && !bus.ivPwrgd[r])
                    fault_mask[r] = 1'b1;
                if ((IW'(r) == idx) && tmo && !bus.ivPwrgd[r])
                    fault_mask[r] = 1'b1;
            end else if (state == ON) begin
                if (vr_en[r] && !bus.ivPwrgd[r])
                    fault_mask[r] = 1'b1;
            end
        end
    end
    assign fault = |fault_mask;

    // State register and registered outputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= OFF;
            idx      <= '0;
            cnt      <= '0;
            vr_en    <= '0;
            srst_n   <= 1'b0;
            all_pg   <= 1'b0;
            pwr_flt  <= 1'b0;
            flt_rail <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            vr_en    <= vr_en_nxt;
            srst_n   <= srst_n_nxt;
            all_pg   <= all_pg_nxt;
            pwr_flt  <= pwr_flt_nxt;
            flt_rail <= flt_rail_nxt;
        end
    end

    // Next state and rail index. Faults win over a power request fall.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            OFF: begin
                idx_nxt = '0;
                if (bus.iPwrReq) state_nxt = STABLE;
            end
            STABLE: begin
                if (!bus.iPwrReq)
                    state_nxt = OFF;
                else if (cnt >= 8'(STABLE_MS)) begin
                    state_nxt = RAMP_UP;
                    idx_nxt   = '0;
                end
            end
            RAMP_UP: begin
                if (fault)
                    state_nxt = FAULT;
                else if (!bus.iPwrReq)
                    state_nxt = RAMP_DN;      // idx already is the highest enabled rail
                else if (pg_cur) begin
                    if (idx == IW'(NUM_RAILS - 1)) state_nxt = ON;
                    else                           idx_nxt   = idx + IW'(1);
                end
            end
            ON: begin
                if (fault)               state_nxt = FAULT;
                else if (!bus.iPwrReq)   state_nxt = RAMP_DN;
            end
            RAMP_DN: begin
                // Power request is ignored here; a stuck PWRGD only delays the step.
                if (!pg_cur || tmo) begin
                    if (idx == '0) state_nxt = OFF;
                    else           idx_nxt   = idx - IW'(1);
                end
            end
            FAULT: begin
                idx_nxt = '0;
                if (bus.iGoOutFltSt) state_nxt = OFF;
            end
            default: begin
                state_nxt = OFF;
                idx_nxt   = '0;
            end
        endcase
    end

    // Next values of the registered outputs and the ms counter.
    always_comb begin
        vr_en_nxt    = vr_en;
        pwr_flt_nxt  = pwr_flt;
        flt_rail_nxt = flt_rail;

        if (state == STABLE && state_nxt == RAMP_UP)
            vr_en_nxt = NUM_RAILS'(1);
        else if (state == RAMP_UP && state_nxt == RAMP_UP && idx_nxt != idx)
            vr_en_nxt[idx_nxt] = 1'b1;
        else if (state == RAMP_DN)
            vr_en_nxt[idx] = 1'b0;

        if (state_nxt == FAULT || state_nxt == OFF)
            vr_en_nxt = '0;

        if (fault) begin
            pwr_flt_nxt  = 1'b1;
            flt_rail_nxt = fault_mask;
        end
        if (state == FAULT && state_nxt == OFF) begin
            pwr_flt_nxt  = 1'b0;
            flt_rail_nxt = '0;
        end

        // Requiring ON now and next drops SRST# on the same edge that leaves ON.
        srst_n_nxt = (state == ON) && (state_nxt == ON) &&
                     (cnt >= 8'(RST_DLY_MS)) && bus.iDediBusy_n;
        all_pg_nxt = (state_nxt == ON) && (&bus.ivPwrgd);

        if (state_nxt != state || idx_nxt != idx)
            cnt_nxt = '0;
        else if (bus.i1mSCE && cnt != 8'hFF)
            cnt_nxt = cnt + 8'd1;
        else
            cnt_nxt = cnt;
    end

    assign bus.ovVrEn    = vr_en;
    assign bus.oSrst_n   = srst_n;
    assign bus.oAllPwrgd = all_pg;
    assign bus.oPwrFlt   = pwr_flt;
    assign bus.ovFltRail = flt_rail;
    assign bus.ovState   = state;
endmodule

// File: doc/aux_rail_seq.md
AUX_RAIL_SEQ -- requirements
Module: aux_rail_seq

Interface
REQ-001 Parameter NUM_RAILS, default 4: number of sequenced VR rails, legal range 1..8; rail 0 is powered first.
REQ-002 Parameter PG_TIMEOUT_MS, default 10: maximum ms from a rail enable to its PWRGD, legal range 1..255.
REQ-003 Parameter STABLE_MS, default 1: ms that iPwrReq must stay high before sequencing starts, legal range 1..255.
REQ-004 Parameter RST_DLY_MS, default 2: ms from all rails good to SRST# release, legal range 1..255.
REQ-005 Ports, one clock iClk; reset iRst is synchronous and active-high:
- iClk  in  1  system clock.
- iRst  in  1  synchronous active-high reset.
- i1mSCE  in  1  single-cycle 1 ms clock enable.
- iGoOutFltSt  in  1  fault-clear request.
- iPwrReq  in  1  power request (SLP_SUS_N class); low requests power-down.
- ivPwrgd  in  NUM_RAILS  per-rail PWRGD.
- iDediBusy_n  in  1  low while the Dediprog programmer holds the flash.
- ovVrEn  out  NUM_RAILS  per-rail VR enable.
- oSrst_n  out  1  BMC SRST#.
- oAllPwrgd  out  1  all rails good and sequence complete.
- oPwrFlt  out  1  sticky fault flag.
- ovFltRail  out  NUM_RAILS  latched mask of faulting rails.
- ovState  out  3  current FSM state encoding.

Function
REQ-006 The FSM shall use states OFF=0, STABLE=1, RAMP_UP=2, ON=3, RAMP_DN=4 and FAULT=5; all outputs shall be registered.
REQ-007 The 8-bit ms counter shall clear on every state change and every rail-index step, and shall increment on i1mSCE, saturating at 255.
REQ-008 Transitions out of OFF and STABLE:
- OFF -> STABLE when iPwrReq=1.
- STABLE -> OFF when iPwrReq=0.
- STABLE -> RAMP_UP when the counter reaches STABLE_MS.
REQ-009 On entry to RAMP_UP, the rail index shall be 0 and ovVrEn[0] shall assert.
- When ivPwrgd[idx]=1: if idx<NUM_RAILS-1, the index increments and ovVrEn[idx+1] asserts in the same cycle; otherwise the FSM goes to ON.
REQ-010 In RAMP_UP, a counter value equal to PG_TIMEOUT_MS while ivPwrgd[idx]=0 shall be a timeout fault on rail idx.
REQ-011 In RAMP_UP (rails below idx) and in ON (all rails), a deassertion of ivPwrgd on any enabled rail shall be a loss fault on that rail.
REQ-012 On any fault:
- FSM -> FAULT.
- ovVrEn clears to 0 on the next cycle.
- oPwrFlt=1.
- ovFltRail latches the OR of all rails faulting in that cycle.
REQ-013 In RAMP_UP or ON, iPwrReq=0 shall move the FSM to RAMP_DN starting at the highest enabled rail.
REQ-014 In RAMP_DN, the current rail's enable shall clear, then the FSM shall wait for ivPwrgd[idx]=0 or for PG_TIMEOUT_MS, and then decrement idx; the step after rail 0 shall go to OFF.
- A timeout during RAMP_DN shall not be a fault.
REQ-015 In RAMP_DN, iPwrReq returning to 1 shall be ignored until OFF is reached.
REQ-016 A fault detected in the same cycle as an iPwrReq fall shall take priority, and the FSM shall go to FAULT.
REQ-017 FAULT shall persist regardless of iPwrReq until iGoOutFltSt=1; that pulse shall:
- clear oPwrFlt and ovFltRail;
- move the FSM to OFF.
REQ-018 iGoOutFltSt shall have no effect outside FAULT.
REQ-019 oAllPwrgd shall be 1 only in ON with all ivPwrgd=1.
REQ-020 oSrst_n shall rise only when all three hold:
- the FSM is in ON;
- the counter is at or above RST_DLY_MS since ON entry;
- iDediBusy_n=1.
REQ-021 oSrst_n shall fall one cycle after any of the following:
- iPwrReq falls, before any rail is disabled;
- a fault occurs;
- iDediBusy_n=0;
- the FSM leaves ON.

Reset
REQ-022 iRst=1 shall, at the next clock edge, set the following, overriding all other inputs including an in-progress ramp:
- state=OFF, index=0, counter=0;
- ovVrEn=0, oSrst_n=0, oAllPwrgd=0;
- oPwrFlt=0, ovFltRail=0.

Verification (NUM_RAILS=4, PG_TIMEOUT_MS=10, STABLE_MS=1, RAMP_DN timeout=10, RST_DLY_MS=2)
REQ-023 Normal power-up: iPwrReq=1 and each PWRGD returns 1 ms after its enable -> ovVrEn steps 0001,0011,0111,1111; oAllPwrgd=1; oSrst_n=1 two ms after ON.
REQ-024 Rail timeout: ivPwrgd[2] held at 0 -> on the 10th 1 ms tick, ovState=5, ovVrEn=0000 next cycle, ovFltRail=0100, oPwrFlt=1.
REQ-025 Power-down from ON: iPwrReq falls -> oSrst_n=0 next cycle; enables clear in the order rail3, rail2, rail1, rail0; ovState=0 after rail0's PWRGD falls.
REQ-026 Simultaneous events: ivPwrgd[1] falls in the same cycle as iPwrReq falls -> FAULT, ovFltRail=0010; iGoOutFltSt pulse -> ovState=0, oPwrFlt=0.
REQ-027 Dediprog and reset: iDediBusy_n=0 while in ON -> oSrst_n=0 with enables held; iRst asserted mid-RAMP_UP -> all outputs at reset values the next cycle.
